// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the control unit / memory controller interface:
// access-size and direction encodings, controller state enum, size helper.
package cpu_mem_pkg;

  // typeData encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // RW encodings
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_XFER = 2'b10,
    ST_DONE = 2'b11
  } mc_state_e;

  // Number of bytes moved for a given access size (0 for the reserved code)
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Single-port byte-wide storage: synchronous write, asynchronous read.
// No reset: contents survive controller resets.
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [0:DEPTH-1];

  // Byte write on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_controller.sv
// Multi-cycle memory controller: accepts a MOV/RW/typeData request, moves
// one byte per cycle after WAIT_STATES idle cycles, and answers with MOC.
// The request is captured on the edge that samples MOV and qualified on the
// following edge, so MOC rises 1 + WAIT_STATES + N edges after sampling
// (one edge for a rejected request). Storage is big-endian.
module mem_controller
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ERR
);

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mc_state_e         state_r, next_state_s;
  logic              accept_r;
  logic [31:0]       addr_r;
  logic              rw_r;
  logic [1:0]        size_r;
  logic [31:0]       wshift_r;
  logic [3:0]        wait_cnt_r;
  logic [2:0]        byte_cnt_r;
  logic [31:0]       dout_r;
  logic              moc_r;
  logic              err_r;

  logic              bad_s;
  logic              last_byte_s;
  logic              latch_s;
  logic              start_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [7:0]        ram_rdata_s;

  // Rejection and end-of-transfer decisions use the held request copy only
  assign bad_s = (size_r == SZ_RSVD)
               | ((size_r == SZ_HALF) && addr_r[0])
               | ((size_r == SZ_WORD) && (addr_r[1:0] != 2'b00))
               | ((addr_r >> ADDR_W) != 32'd0);
  assign last_byte_s = (byte_cnt_r == (size_to_bytes(size_r) - 3'd1));

  // State register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_r) begin
          if (bad_s) begin
            next_state_s = ST_DONE;
          end else if (WAIT_STATES == 0) begin
            next_state_s = ST_XFER;
          end else begin
            next_state_s = ST_WAIT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          next_state_s = ST_XFER;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_XFER: begin
        if (last_byte_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_XFER;
        end
      end
      ST_DONE: begin
        if (!MOV) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    latch_s    = (state_r == ST_IDLE) && !accept_r && MOV;
    start_s    = (state_r == ST_IDLE) && accept_r;
    ram_we_s   = (state_r == ST_XFER) && (rw_r == RW_WRITE);
    ram_addr_s = addr_r[ADDR_W-1:0] + ADDR_W'(byte_cnt_r);
  end

  // Request capture, counters, data lanes and registered handshake outputs
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      accept_r   <= 1'b0;
      addr_r     <= 32'd0;
      rw_r       <= 1'b0;
      size_r     <= 2'b00;
      wshift_r   <= 32'd0;
      wait_cnt_r <= 4'd0;
      byte_cnt_r <= 3'd0;
      dout_r     <= 32'd0;
      moc_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      accept_r <= latch_s;
      if (latch_s) begin
        addr_r <= Address;
        rw_r   <= RW;
        size_r <= typeData;
        // Left-justify the write data so the first byte out is always [31:24]
        case (typeData)
          SZ_BYTE: wshift_r <= {DataIn[7:0], 24'd0};
          SZ_HALF: wshift_r <= {DataIn[15:0], 16'd0};
          default: wshift_r <= DataIn;
        endcase
      end else if (state_r == ST_XFER) begin
        wshift_r <= {wshift_r[23:0], 8'd0};
      end else begin
        wshift_r <= wshift_r;
      end

      wait_cnt_r <= (state_r == ST_WAIT) ? (wait_cnt_r + 4'd1) : 4'd0;
      byte_cnt_r <= (state_r == ST_XFER) ? (byte_cnt_r + 3'd1) : 3'd0;

      // Reads shift bytes in from the right, which yields big-endian lanes
      if (start_s && (bad_s || (rw_r == RW_READ))) begin
        dout_r <= 32'd0;
      end else if ((state_r == ST_XFER) && (rw_r == RW_READ)) begin
        dout_r <= {dout_r[23:0], ram_rdata_s};
      end else begin
        dout_r <= dout_r;
      end

      moc_r <= (next_state_s == ST_DONE);
      err_r <= (next_state_s == ST_DONE) && bad_s;
    end
  end

  assign DataOut = dout_r;
  assign MOC     = moc_r;
  assign ERR     = err_r;

  ram_byte_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wshift_r[31:24]),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: expected results are queued when a
// request is driven and compared when MOC is observed; a byte-level model
// of the array tracks every write.
module tb_mem_controller;
  import cpu_mem_pkg::*;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        mov;
  logic        rw;
  logic [1:0]  type_data;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] last_dout;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
    .CLK      (clk),
    .CLR      (clr),
    .MOV      (mov),
    .RW       (rw),
    .typeData (type_data),
    .Address  (address),
    .DataIn   (data_in),
    .DataOut  (data_out),
    .MOC      (moc),
    .ERR      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("%s mem[%0d]", tag, i), {24'd0, dut.u_ram.mem[i]}, {24'd0, ref_mem[i]});
    end
  endtask

  // Builds the expected result, updates the array model, pushes to the queue
  task automatic predict(input logic r, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   ai;
    logic bad;
    bad = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00))
       || (a[31:8] != 24'd0);
    ai = int'(a[7:0]);
    e.err = bad;
    if (bad) begin
      e.dout = 32'd0;
      e.lat  = 1;
    end else begin
      e.lat = 1 + WS + ((sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4);
      if (r) begin
        case (sz)
          2'b00:   e.dout = {24'd0, ref_mem[ai]};
          2'b01:   e.dout = {16'd0, ref_mem[ai], ref_mem[ai+1]};
          default: e.dout = {ref_mem[ai], ref_mem[ai+1], ref_mem[ai+2], ref_mem[ai+3]};
        endcase
      end else begin
        e.dout = last_dout;
        case (sz)
          2'b00: ref_mem[ai] = d[7:0];
          2'b01: begin ref_mem[ai] = d[15:8]; ref_mem[ai+1] = d[7:0]; end
          default: begin
            ref_mem[ai] = d[31:24]; ref_mem[ai+1] = d[23:16];
            ref_mem[ai+2] = d[15:8]; ref_mem[ai+3] = d[7:0];
          end
        endcase
      end
    end
    last_dout = e.dout;
    sb_q.push_back(e);
  endtask

  // Drives one request (caller is at a negedge), waits for MOC, then keeps
  // MOV high for 'hold' extra cycles before releasing it
  task automatic run_req(input string tag, input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    predict(r, sz, a, d);
    rw = r; type_data = sz; address = a; data_in = d; mov = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // Request inputs are ignored while busy
      rw = ~r; type_data = 2'($urandom_range(3)); address = $urandom; data_in = $urandom;
      if (moc) seen = 1;
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, " empty_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " dout"}, data_out, e.dout);
      check({tag, " err"}, {31'd0, err}, {31'd0, e.err});
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " moc_hold"}, {31'd0, moc}, 32'd1);
    end
    mov = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " moc_drop"}, {31'd0, moc}, 32'd0);
    check_mem(tag);
  endtask

  initial begin
    clr = 1'b0; mov = 1'b0; rw = 1'b1; type_data = 2'b00; address = 32'd0; data_in = 32'd0;
    last_dout = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end
    ref_mem[0] = 8'h8C; ref_mem[1] = 8'h12; ref_mem[2] = 8'h34; ref_mem[3] = 8'h56;
    for (int i = 0; i < 256; i++) begin
      dut.u_ram.mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset moc", {31'd0, moc}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset dout", data_out, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    run_req("rd_word_0",  1'b1, SZ_WORD, 32'd0, 32'd0, 0);
    run_req("wr_word_4",  1'b0, SZ_WORD, 32'd4, 32'hDEADBEEF, 0);
    run_req("rd_half_6",  1'b1, SZ_HALF, 32'd6, 32'd0, 0);
    run_req("rd_byte_5",  1'b1, SZ_BYTE, 32'd5, 32'd0, 0);
    run_req("wr_byte_9",  1'b0, SZ_BYTE, 32'd9, 32'hFFFFFF5A, 0);
    run_req("wr_half_16", 1'b0, SZ_HALF, 32'd16, 32'hAAAA7E81, 0);
    run_req("rd_word_16", 1'b1, SZ_WORD, 32'd16, 32'd0, 0);
    run_req("bad_half_3", 1'b1, SZ_HALF, 32'd3, 32'd0, 0);
    run_req("bad_word_2", 1'b1, SZ_WORD, 32'd2, 32'd0, 0);
    run_req("bad_rsvd",   1'b1, SZ_RSVD, 32'd0, 32'd0, 0);
    run_req("bad_range",  1'b1, SZ_WORD, 32'h00000100, 32'd0, 0);
    run_req("bad_wr_rng", 1'b0, SZ_BYTE, 32'h00010000, 32'h00000077, 0);
    run_req("hold_rd_4",  1'b1, SZ_WORD, 32'd4, 32'd0, 3);
    run_req("next_rd_8",  1'b1, SZ_HALF, 32'd8, 32'd0, 0);

    // Reset during the XFER of a word write, after two bytes have landed
    rw = RW_WRITE; type_data = SZ_WORD; address = 32'd12; data_in = 32'h11223344; mov = 1'b1;
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("midrst moc", {31'd0, moc}, 32'd0);
    check("midrst err", {31'd0, err}, 32'd0);
    check("midrst dout", data_out, 32'd0);
    check("midrst state", {30'd0, dut.state_r}, {30'd0, ST_IDLE});
    mov = 1'b0;
    ref_mem[12] = 8'h11;
    ref_mem[13] = 8'h22;
    last_dout = 32'd0;
    check_mem("midrst");
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    run_req("after_rst_12", 1'b1, SZ_WORD, 32'd12, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
